// File: rtl/pll_clkgen_model.sv
// Cycle-accurate PLL model: per-channel divided clocks/enables from one reference,
// with lock acquisition, power-down and valid/ready reconfiguration.
module pll_clkgen_model #(
  parameter int unsigned CHANNELS    = 6,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned LOCK_CYCLES = 64,
  parameter logic [CHANNELS*CNT_W-1:0] DEF_DIV   = {CHANNELS{CNT_W'(1)}},
  parameter logic [CHANNELS*CNT_W-1:0] DEF_PHASE = '0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                pwrdwn,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [2:0]          cfg_sel,
  input  logic [CNT_W-1:0]    cfg_div,
  input  logic [CNT_W-1:0]    cfg_phase,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] clk_en,
  output logic                locked
);

  localparam int unsigned LCW = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]   ONE_X = (CNT_W + 1)'(1);

  typedef enum logic [1:0] {ACQUIRE, LOCKED, PWRDN} state_e;

  state_e           state_q, state_d;
  logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [CNT_W-1:0] div_q   [CHANNELS];
  logic [CNT_W-1:0] div_d   [CHANNELS];
  logic [CNT_W-1:0] phase_q [CHANNELS];
  logic [CNT_W-1:0] phase_d [CHANNELS];
  logic [CNT_W-1:0] cnt_q   [CHANNELS];
  logic [CNT_W-1:0] cnt_d   [CHANNELS];
  logic             cfg_err_q, cfg_err_d;
  logic             cfg_ok;
  logic [CNT_W:0]   half;

  always_comb begin
    cfg_ready = ~pwrdwn & (state_q != PWRDN);
    cfg_ok    = (cfg_div != '0) && (cfg_phase < cfg_div) && (32'(cfg_sel) < CHANNELS);
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    cfg_err_d  = 1'b0;
    div_d      = div_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;

    if (pwrdwn) begin
      state_d    = PWRDN;
      lock_cnt_d = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) cnt_d[i] = '0;
    end else begin
      unique case (state_q)
        PWRDN: begin
          state_d    = ACQUIRE;
          lock_cnt_d = '0;
        end
        ACQUIRE: begin
          lock_cnt_d = lock_cnt_q + LCW'(1);
          if (lock_cnt_q == LCW'(LOCK_CYCLES - 1)) begin
            state_d = LOCKED;
            // Preload so the phase-P channel hits cnt==0 P cycles after a phase-0 one.
            for (int unsigned i = 0; i < CHANNELS; i++)
              cnt_d[i] = (phase_q[i] == '0) ? '0 : div_q[i] - phase_q[i];
          end
        end
        LOCKED: begin
          for (int unsigned i = 0; i < CHANNELS; i++)
            cnt_d[i] = (cnt_q[i] == div_q[i] - ONE) ? '0 : cnt_q[i] + ONE;
        end
        default: state_d = ACQUIRE;
      endcase

      if (cfg_valid && cfg_ready) begin
        if (cfg_ok) begin
          for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (32'(cfg_sel) == i) begin
              div_d[i]   = cfg_div;
              phase_d[i] = cfg_phase;
            end
          end
          state_d    = ACQUIRE;
          lock_cnt_d = '0;
        end else begin
          cfg_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ACQUIRE;
      lock_cnt_q <= '0;
      cfg_err_q  <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        div_q[i]   <= DEF_DIV[i*CNT_W +: CNT_W];
        phase_q[i] <= DEF_PHASE[i*CNT_W +: CNT_W];
        cnt_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      cfg_err_q  <= cfg_err_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    locked  = (state_q == LOCKED);
    cfg_err = cfg_err_q;
    clk_out = '0;
    clk_en  = '0;
    half    = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      // Extra bit so the rounding-up half-period survives div = 2**CNT_W-1.
      half       = ({1'b0, div_q[i]} + ONE_X) >> 1;
      clk_out[i] = locked & ({1'b0, cnt_q[i]} < half);
      clk_en[i]  = locked & (cnt_q[i] == div_q[i] - ONE);
    end
  end

endmodule

// File: tb/tb_pll_clkgen_model.sv
// Directed bench for pll_clkgen_model: lock timing, divide/phase patterns,
// invalid configs, power-down, collisions and async reset.
module tb_pll_clkgen_model;

  localparam int unsigned CH = 6;
  localparam int unsigned W  = 8;
  localparam int unsigned LC = 16;
  localparam logic [CH*W-1:0] DDIV = {8'd1, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1};

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          pwrdwn = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [2:0]    cfg_sel = '0;
  logic [W-1:0]  cfg_div = '0;
  logic [W-1:0]  cfg_phase = '0;
  logic          cfg_err;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] clk_en;
  logic          locked;

  always #5 clk = ~clk;

  pll_clkgen_model #(
    .CHANNELS(CH), .CNT_W(W), .LOCK_CYCLES(LC), .DEF_DIV(DDIV), .DEF_PHASE('0)
  ) dut (
    .clk(clk), .resetn(resetn), .pwrdwn(pwrdwn),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
    .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_err(cfg_err),
    .clk_out(clk_out), .clk_en(clk_en), .locked(locked)
  );

  typedef struct {
    logic          pd;
    logic          v;
    logic [2:0]    sel;
    logic [W-1:0]  dv;
    logic [W-1:0]  ph;
    logic          lk;
    logic [CH-1:0] co;
    logic [CH-1:0] ce;
    logic          err;
    logic          rdy;
  } vec_t;

  vec_t tbl [7];
  int n_chk  = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [2:0] s, input logic [W-1:0] d, input logic [W-1:0] p);
    cfg_valid = 1'b1;
    cfg_sel   = s;
    cfg_div   = d;
    cfg_phase = p;
  endtask

  task automatic acquire15(input string nm);
    for (int i = 0; i < 15; i++) begin
      step();
      chk({nm, "_acq_locked"}, 32'(locked), 32'd0);
    end
  endtask

  task automatic wait_lock(input string nm);
    acquire15(nm);
    step();
    chk({nm, "_lock_edge"}, 32'(locked), 32'd1);
  endtask

  task automatic chk_ch1_ph1(input string nm);
    logic p1 [4];
    logic p3 [4];
    p1 = '{1'b0, 1'b1, 1'b1, 1'b0};
    p3 = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      chk({nm, "_ch1"}, 32'(clk_out[1]), 32'(p1[k % 4]));
      chk({nm, "_ch3"}, 32'(clk_out[3]), 32'(p3[k % 4]));
    end
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b1, 6'b111111, 6'b110001, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b1, 6'b111101, 6'b110011, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 3'd1, 8'd0, 8'd0, 1'b1, 6'b110011, 6'b110101, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 3'd1, 8'd4, 8'd5, 1'b1, 6'b110101, 6'b111011, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 3'd7, 8'd4, 8'd0, 1'b1, 6'b111111, 6'b110001, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b1, 6'b111001, 6'b110111, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 3'd1, 8'd4, 8'd1, 1'b0, 6'b000000, 6'b000000, 1'b0, 1'b1};

    // Reset state
    #2;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_clk_en", 32'(clk_en), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    step();
    resetn = 1'b1;
    acquire15("init");

    // Lock edge, divide patterns, invalid configs, then the phase reconfig
    for (int i = 0; i < 7; i++) begin
      pwrdwn    = tbl[i].pd;
      cfg_valid = tbl[i].v;
      cfg_sel   = tbl[i].sel;
      cfg_div   = tbl[i].dv;
      cfg_phase = tbl[i].ph;
      step();
      chk($sformatf("v%0d_locked", i), 32'(locked), 32'(tbl[i].lk));
      chk($sformatf("v%0d_clk_out", i), 32'(clk_out), 32'(tbl[i].co));
      chk($sformatf("v%0d_clk_en", i), 32'(clk_en), 32'(tbl[i].ce));
      chk($sformatf("v%0d_cfg_err", i), 32'(cfg_err), 32'(tbl[i].err));
      chk($sformatf("v%0d_cfg_ready", i), 32'(cfg_ready), 32'(tbl[i].rdy));
    end
    cfg_valid = 1'b0;
    wait_lock("phase");
    chk_ch1_ph1("phase");

    // Power-down colliding with a config request
    pwrdwn = 1'b1;
    set_cfg(3'd1, 8'd2, 8'd0);
    #1;
    chk("pd_ready_comb", 32'(cfg_ready), 32'd0);
    step();
    chk("pd_locked", 32'(locked), 32'd0);
    chk("pd_clk_out", 32'(clk_out), 32'd0);
    chk("pd_clk_en", 32'(clk_en), 32'd0);
    chk("pd_ready", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    repeat (9) step();
    chk("pd_hold_locked", 32'(locked), 32'd0);
    pwrdwn = 1'b0;
    #1;
    chk("pd_exit_ready", 32'(cfg_ready), 32'd0);
    step();
    chk("pd_acq_ready", 32'(cfg_ready), 32'd1);
    wait_lock("pd_relock");
    chk_ch1_ph1("pd_relock");

    // Config accepted mid-acquire restarts the lock count
    set_cfg(3'd2, 8'd3, 8'd0);
    step();
    chk("acq_cfg_locked", 32'(locked), 32'd0);
    cfg_valid = 1'b0;
    repeat (10) step();
    set_cfg(3'd2, 8'd3, 8'd2);
    step();
    chk("acq_cfg_err", 32'(cfg_err), 32'd0);
    cfg_valid = 1'b0;
    wait_lock("acq_restart");
    begin
      logic po [6];
      logic pe [6];
      po = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      pe = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int k = 0; k < 6; k++) begin
        if (k > 0) step();
        chk("ch2_ph2_out", 32'(clk_out[2]), 32'(po[k]));
        chk("ch2_ph2_en", 32'(clk_en[2]), 32'(pe[k]));
      end
    end

    // Asynchronous reset mid-LOCKED restores default divides
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_clk_out", 32'(clk_out), 32'd0);
    chk("arst_clk_en", 32'(clk_en), 32'd0);
    step();
    resetn = 1'b1;
    wait_lock("arst");
    begin
      logic p1 [6];
      logic p2 [6];
      p1 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      p2 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int k = 0; k < 6; k++) begin
        if (k > 0) step();
        chk("arst_ch1", 32'(clk_out[1]), 32'(p1[k]));
        chk("arst_ch2", 32'(clk_out[2]), 32'(p2[k]));
        chk("arst_ch0_en", 32'(clk_en[0]), 32'd1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_miss);
    $finish;
  end

endmodule

// File: doc/pll_clkgen_model.md
Name: pll_clkgen_model

Overview:
- Cycle-accurate, synthesizable behavioural model of a multi-output PLL, for simulation and FPGA-agnostic builds.
- Derives CHANNELS divided clocks and clock-enables from one reference clock.
- Per-channel programmable divide and phase, lock-acquisition timing, power-down, and runtime reconfiguration over a valid/ready port.
- Replaces dummy PLL stubs wherever downstream logic needs realistic LOCKED and clock-enable behaviour.

Parameters:
- CHANNELS, 6: number of output channels, 1..8.
- CNT_W, 8: width of divide/phase values and per-channel counters.
- LOCK_CYCLES, 64: reference cycles spent in ACQUIRE before lock, >=1.
- DEF_DIV, {CHANNELS{8'd1}}: packed reset divide values, channel 0 in the LSBs; each field must be >=1.
- DEF_PHASE, 0: packed reset phase values; each field must be < its DEF_DIV field.

Ports:
- clk  in  1  reference clock.
- resetn  in  1  asynchronous active-low reset.
- pwrdwn  in  1  power-down request, level-sensitive.
- cfg_valid  in  1  reconfiguration request.
- cfg_ready  out  1  reconfiguration accept.
- cfg_sel  in  3  channel index.
- cfg_div  in  CNT_W  new divide value.
- cfg_phase  in  CNT_W  new phase, in reference cycles.
- cfg_err  out  1  one-cycle pulse on a rejected config.
- clk_out  out  CHANNELS  divided clock per channel.
- clk_en  out  CHANNELS  one-cycle enable per channel period.
- locked  out  1  lock indication.

Behaviour:
- One clock domain. Reset is asynchronous and active-low on resetn.
- Reset state:
  - FSM = ACQUIRE, lock_cnt = 0.
  - div[i] = DEF_DIV field, phase[i] = DEF_PHASE field, cnt[i] = 0.
  - locked = 0, clk_out = 0, clk_en = 0, cfg_err = 0.
- FSM states: ACQUIRE, LOCKED, PWRDN.
- ACQUIRE:
  - lock_cnt increments by 1 each cycle.
  - When lock_cnt == LOCK_CYCLES-1: next state is LOCKED, and every cnt[i] loads (div[i]-phase[i]) mod div[i].
  - Consequence: locked rises exactly LOCK_CYCLES edges after entry into ACQUIRE.
- LOCKED:
  - cnt[i] wraps: next = 0 if cnt[i] == div[i]-1, else cnt[i]+1.
- PWRDN:
  - Entered from any state on the edge where pwrdwn = 1.
  - On the edge where pwrdwn returns to 0, go to ACQUIRE with lock_cnt = 0.
- Outputs are combinational from registered state only:
  - locked = (state == LOCKED).
  - clk_out[i] = locked & (cnt[i] < (div[i]+1)>>1). For div = 1 this holds at 1; odd divides are high for the extra cycle.
  - clk_en[i] = locked & (cnt[i] == div[i]-1). For div = 1 this holds at 1.
- Phase: a channel with phase P has its cnt = 0 cycle exactly P reference cycles after that of the same channel with phase 0.
- Reconfiguration:
  - cfg_ready = ~pwrdwn & (state != PWRDN).
  - A transfer occurs when cfg_valid & cfg_ready on an edge.
  - Valid transfer: cfg_div >= 1, cfg_phase < cfg_div, cfg_sel < CHANNELS.
    - Update div[cfg_sel] and phase[cfg_sel].
    - Next state ACQUIRE, lock_cnt = 0, so locked drops the next cycle.
    - Applies in ACQUIRE too, restarting the lock count.
  - Invalid transfer: registers unchanged, no relock, cfg_err = 1 for exactly one cycle.
  - The transfer is still consumed; cfg_ready stays high.
- Simultaneous events: pwrdwn = 1 with cfg_valid = 1 means cfg_ready = 0, the config is ignored, and PWRDN wins.
- Reset mid-operation: immediate return to reset values, including div/phase back to defaults.
- Width rules: all counter comparisons at CNT_W bits. lock_cnt width is clog2(LOCK_CYCLES+1).

Test Plan:
- Lock timing. Bench: LOCK_CYCLES=16, DEF_DIV ch0..2 = 1,2,3. Release resetn → locked rises on the 16th edge. Then:
  - ch0 clk_out and clk_en constant 1.
  - ch1 clk_out = 1,0,1,0.
  - ch2 clk_out = 1,1,0 repeating, with clk_en high on the third cycle.
- Phase: cfg ch1 div = 4, phase = 1 → locked drops for 16 cycles, then ch1 clk_out = 0,1,1,0 repeating, with its rising edge 1 cycle after a phase-0 div-4 reference channel.
- Invalid config: cfg_div = 0, or cfg_phase = 5 with cfg_div = 4, or cfg_sel = 7 with CHANNELS = 6 → cfg_err pulses 1 cycle, locked stays 1, outputs unchanged.
- Power-down: assert pwrdwn for 10 cycles while locked → next edge locked = 0 and all outputs 0, cfg_ready = 0. Deassert → relock after 16 cycles with phases restored.
- Collisions: pwrdwn and cfg_valid in the same cycle → config dropped, div unchanged after relock. cfg accepted during ACQUIRE at lock_cnt = 10 → lock occurs 16 cycles after the accept.
- Async reset: drop resetn mid-LOCKED after a reconfig → outputs 0 immediately without a clock edge, and div returns to DEF_DIV.
